// File: rtl/shared_resource_pipelined_pkg.sv
// Shared defaults and helpers for the pipelined shared-resource model.
// Keeping the defaults here means every instantiation in the system starts
// from the same widths, depth, latency and offset.
package shared_resource_pipelined_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ID_WIDTH      = 4;
  localparam int RESOURCE_DEPTH    = 4;
  localparam int RESOURCE_DELAY    = 4;
  localparam int RESOURCE_OFFSET   = 512;

  // Pointer width for a circular buffer; a single-slot buffer still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must represent the values 0..max_value.
  function automatic int count_width(input int max_value);
    return (max_value > 0) ? $clog2(max_value + 1) : 1;
  endfunction

endpackage

// File: rtl/shared_resource_pipelined_if.sv
// Request/response bundle of the shared resource: request handshake in,
// result handshake out, plus the occupancy report.
interface shared_resource_pipelined_if
  import shared_resource_pipelined_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int DEPTH         = RESOURCE_DEPTH
);

  localparam int OCC_WIDTH = count_width(DEPTH);

  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [ID_WIDTH-1:0]      in_id;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [ID_WIDTH-1:0]      out_id;
  logic                     out_valid;
  logic                     out_ready;
  logic [OCC_WIDTH-1:0]     occupancy;

  // Requester / consumer side.
  modport master (
    output in_address, in_id, in_valid, out_ready,
    input  in_ready, out_data, out_id, out_valid, occupancy
  );

  // Resource side.
  modport slave (
    input  in_address, in_id, in_valid, out_ready,
    output in_ready, out_data, out_id, out_valid, occupancy
  );

endinterface

// File: rtl/shared_resource_pipelined_slot_fifo.sv
// Circular buffer of DEPTH slots, each carrying data, id and an age counter.
// A slot's age is 0 while free, 1 on the cycle after it is written, and then
// counts up each cycle until it saturates at DELAY, which marks it complete.
module resource_slot_fifo
  import shared_resource_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DEPTH      = RESOURCE_DEPTH,
  parameter int DELAY      = RESOURCE_DELAY
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            push_i,
  input  logic [DATA_WIDTH-1:0]           push_data_i,
  input  logic [ID_WIDTH-1:0]             push_id_i,
  input  logic                            pop_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            head_done_o,
  output logic [DATA_WIDTH-1:0]           head_data_o,
  output logic [ID_WIDTH-1:0]             head_id_o,
  output logic [count_width(DEPTH)-1:0]   count_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AGE_W = count_width(DELAY);
  localparam int CNT_W = count_width(DEPTH);
  localparam logic [AGE_W-1:0] AGE_DONE = AGE_W'(DELAY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0] slot_data [DEPTH];
  logic [ID_WIDTH-1:0]   slot_id   [DEPTH];
  logic [AGE_W-1:0]      slot_age  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] data_q;
      logic [ID_WIDTH-1:0]   id_q;
      logic [AGE_W-1:0]      age_q;
      logic                  write_here;
      logic                  free_here;

      // The top never pushes into a full buffer, so a slot is never written
      // and freed on the same edge.
      assign write_here = push_i && (tail_q == PTR_W'(gi));
      assign free_here  = pop_i  && (head_q == PTR_W'(gi));

      // Per-slot storage: capture on write, clear age on free, else age up to DELAY.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_q <= '0;
          id_q   <= '0;
          age_q  <= '0;
        end else if (write_here) begin
          data_q <= push_data_i;
          id_q   <= push_id_i;
          age_q  <= AGE_W'(1);
        end else if (free_here) begin
          age_q  <= '0;
        end else if ((age_q != '0) && (age_q != AGE_DONE)) begin
          age_q  <= age_q + AGE_W'(1);
        end
      end

      assign slot_data[gi] = data_q;
      assign slot_id[gi]   = id_q;
      assign slot_age[gi]  = age_q;
    end
  endgenerate

  // Pointer and count next-state; wrap by explicit compare so any DEPTH works.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
    end
    if (pop_i) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_done_o = (slot_age[head_q] == AGE_DONE);
  assign head_data_o = slot_data[head_q];
  assign head_id_o   = slot_id[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/shared_resource_pipelined.sv
// Pipelined shared resource: accepts up to DEPTH requests in flight, turns
// each address into address + OFFSET after a fixed DELAY, and returns the
// results in acceptance order behind a valid/ready handshake.
module shared_resource_pipelined
  import shared_resource_pipelined_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int DEPTH         = RESOURCE_DEPTH,
  parameter int DELAY         = RESOURCE_DELAY,
  parameter int OFFSET        = RESOURCE_OFFSET
) (
  input logic                    clk,
  input logic                    reset_n,
  shared_resource_pipelined_if.slave bus
);

  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_head_done;
  logic [DATA_WIDTH-1:0]         fifo_head_data;
  logic [ID_WIDTH-1:0]           fifo_head_id;
  logic [count_width(DEPTH)-1:0] fifo_count;
  logic [DATA_WIDTH-1:0]         push_data;
  logic                          push;
  logic                          pop;

  // Result is the zero-extended address plus OFFSET, wrapping at DATA_WIDTH.
  assign push_data = DATA_WIDTH'(bus.in_address) + DATA_WIDTH'(OFFSET);

  // Handshake decode: ready depends only on registered fill level, never on
  // out_ready, so a full buffer pops first and accepts on the following edge.
  always_comb begin
    bus.in_ready  = !fifo_full;
    bus.out_valid = !fifo_empty && fifo_head_done;
    push          = bus.in_valid && !fifo_full;
    pop           = !fifo_empty && fifo_head_done && bus.out_ready;
  end

  assign bus.out_data  = fifo_head_data;
  assign bus.out_id    = fifo_head_id;
  assign bus.occupancy = fifo_count;

  resource_slot_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .DEPTH      (DEPTH),
    .DELAY      (DELAY)
  ) u_slot_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .push_id_i   (bus.in_id),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_done_o (fifo_head_done),
    .head_data_o (fifo_head_data),
    .head_id_o   (fifo_head_id),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_shared_resource_pipelined.sv
// Bench for shared_resource_pipelined: two instances (default configuration,
// and a DEPTH=3 / 10-bit / DELAY=5 variant) see identical stimulus and are
// each compared every cycle against a queue-based reference model.
module tb_shared_resource_pipelined;

  localparam int A_AW = 8,  A_DW = 16, A_IW = 4, A_DEPTH = 4, A_DELAY = 4;
  localparam int B_AW = 10, B_DW = 10, B_IW = 4, B_DEPTH = 3, B_DELAY = 5;
  localparam int OFFSET = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       st_valid = 1'b0;
  logic [9:0] st_addr  = '0;
  logic [3:0] st_id    = '0;
  logic       st_ordy  = 1'b0;

  shared_resource_pipelined_if #(.ADDRESS_WIDTH(A_AW), .DATA_WIDTH(A_DW),
                                 .ID_WIDTH(A_IW), .DEPTH(A_DEPTH)) bus_a ();
  shared_resource_pipelined_if #(.ADDRESS_WIDTH(B_AW), .DATA_WIDTH(B_DW),
                                 .ID_WIDTH(B_IW), .DEPTH(B_DEPTH)) bus_b ();

  assign bus_a.in_valid   = st_valid;
  assign bus_a.in_address = st_addr[7:0];
  assign bus_a.in_id      = st_id;
  assign bus_a.out_ready  = st_ordy;
  assign bus_b.in_valid   = st_valid;
  assign bus_b.in_address = st_addr;
  assign bus_b.in_id      = st_id;
  assign bus_b.out_ready  = st_ordy;

  shared_resource_pipelined #(
    .ADDRESS_WIDTH(A_AW), .DATA_WIDTH(A_DW), .ID_WIDTH(A_IW),
    .DEPTH(A_DEPTH), .DELAY(A_DELAY), .OFFSET(OFFSET)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  shared_resource_pipelined #(
    .ADDRESS_WIDTH(B_AW), .DATA_WIDTH(B_DW), .ID_WIDTH(B_IW),
    .DEPTH(B_DEPTH), .DELAY(B_DELAY), .OFFSET(OFFSET)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  // Reference model: each accepted request remembers the edge number it was
  // accepted on; it is complete once DELAY-1 further edges have passed.
  typedef struct {
    int unsigned data;
    int unsigned id;
    int unsigned k;
  } entry_t;

  entry_t      mq [2][$];
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int depth_of(input int d);
    return (d == 0) ? A_DEPTH : B_DEPTH;
  endfunction
  function automatic int delay_of(input int d);
    return (d == 0) ? A_DELAY : B_DELAY;
  endfunction
  function automatic int unsigned amask(input int d);
    return (d == 0) ? ((32'd1 << A_AW) - 1) : ((32'd1 << B_AW) - 1);
  endfunction
  function automatic int unsigned dmask(input int d);
    return (d == 0) ? ((32'd1 << A_DW) - 1) : ((32'd1 << B_DW) - 1);
  endfunction

  function automatic bit model_valid(input int d);
    if (mq[d].size() == 0) return 1'b0;
    return edge_cnt >= mq[d][0].k + int'(delay_of(d)) - 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic compare_dut(input int d, input logic ir, input logic ov,
                             input logic [31:0] od, input logic [31:0] oi,
                             input logic [31:0] occ);
    string p;
    bit    exp_ov;
    p = (d == 0) ? "A" : "B";
    exp_ov = model_valid(d);
    check_eq({p, ".in_ready"},  32'(ir),  32'(mq[d].size() < depth_of(d)));
    check_eq({p, ".out_valid"}, 32'(ov),  32'(exp_ov));
    check_eq({p, ".occupancy"}, occ,      32'(mq[d].size()));
    if (exp_ov) begin
      check_eq({p, ".out_data"}, od, mq[d][0].data);
      check_eq({p, ".out_id"},   oi, mq[d][0].id);
    end
  endtask

  task automatic compare_both();
    compare_dut(0, bus_a.in_ready, bus_a.out_valid, 32'(bus_a.out_data),
                32'(bus_a.out_id), 32'(bus_a.occupancy));
    compare_dut(1, bus_b.in_ready, bus_b.out_valid, 32'(bus_b.out_data),
                32'(bus_b.out_id), 32'(bus_b.occupancy));
  endtask

  // Outputs must all be at their reset values (checked while reset is held).
  task automatic check_reset_values();
    check_eq("A.rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    check_eq("A.rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("A.rst_out_data",  32'(bus_a.out_data),  32'd0);
    check_eq("A.rst_out_id",    32'(bus_a.out_id),    32'd0);
    check_eq("A.rst_occupancy", 32'(bus_a.occupancy), 32'd0);
    check_eq("B.rst_in_ready",  32'(bus_b.in_ready),  32'd1);
    check_eq("B.rst_out_valid", 32'(bus_b.out_valid), 32'd0);
    check_eq("B.rst_out_data",  32'(bus_b.out_data),  32'd0);
    check_eq("B.rst_out_id",    32'(bus_b.out_id),    32'd0);
    check_eq("B.rst_occupancy", 32'(bus_b.occupancy), 32'd0);
  endtask

  // One clock cycle: drive, check before the edge, then advance the model.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input bit v, input int unsigned addr, input int unsigned id, input bit ordy);
    bit acc [2];
    bit pop [2];
    entry_t e;
    st_valid = v;
    st_addr  = addr[9:0];
    st_id    = id[3:0];
    st_ordy  = ordy;
    @(negedge clk);
    compare_both();
    for (int d = 0; d < 2; d++) begin
      acc[d] = v && (mq[d].size() < depth_of(d));
      pop[d] = model_valid(d) && ordy;
    end
    @(posedge clk);
    edge_cnt++;
    for (int d = 0; d < 2; d++) begin
      if (pop[d]) begin
        $display("%s pop  id=%0d data=0x%0h at edge %0d", (d == 0) ? "A" : "B",
                 mq[d][0].id, mq[d][0].data, edge_cnt);
        void'(mq[d].pop_front());
      end
      if (acc[d]) begin
        e.data = ((addr & amask(d)) + OFFSET) & dmask(d);
        e.id   = id & 32'hF;
        e.k    = edge_cnt;
        mq[d].push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    // Power-on reset.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset_n = 1'b1;

    // Single request: address 0x05, id 3, consumer always ready.
    step(1'b1, 32'h05, 3, 1'b1);
    idle(8);

    // Streaming: 8 back-to-back requests, ids 0..7.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + i, i, 1'b1);
    idle(10);

    // Backpressure: six requests offered while the consumer stalls, then held
    // until the buffer fills and the head completes; then a push/pop at full.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h40 + i, i, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h46, 6, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h46, 6, 1'b1);
    idle(10);

    // Overflow of the result: 0xFF gives 0x2FF, 0x3FF wraps to 0x1FF in 10 bits.
    for (int i = 0; i < 10; i++) step(1'b1, 32'hFF, i, 1'b1);
    idle(8);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3FF, i, 1'b1);
    idle(8);

    // Randomised traffic with random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
           $urandom_range(0, 15), $urandom_range(0, 2) != 0);
    end
    idle(12);

    // Reset mid-flight: two requests, reset asserted between edges once the
    // first has reached age 2; nothing may emerge after release.
    step(1'b1, 32'h21, 9, 1'b1);
    step(1'b1, 32'h22, 10, 1'b1);
    st_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    mq[0].delete();
    mq[1].delete();
    @(posedge clk);
    #1;
    check_reset_values();
    reset_n = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
